// File: rtl/code_convert_pipe_if.sv
// Handshake bundle for code_convert_pipe: input word side, registered output side.
// The optional out_err signal exists only when CODE_CONV_ONEHOT_CHK_EN is defined.
interface code_convert_pipe_if #(
  parameter int N = 4
);
  localparam int W = 2 ** N;

  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_none;
`ifdef CODE_CONV_ONEHOT_CHK_EN
  logic         out_err;

  // Producer/consumer view (testbench or surrounding logic).
  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_none, out_err
  );

  // Converter view.
  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_none, out_err
  );
`else
  // Producer/consumer view (testbench or surrounding logic).
  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_none
  );

  // Converter view.
  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_none
  );
`endif
endinterface

// File: rtl/code_convert_pipe.sv
// Registered N-to-2^N decoder / 2^N-to-N priority encoder with valid/ready
// handshake, global enable and a saturating output-transfer counter.
// Optional feature macro: CODE_CONV_ONEHOT_CHK_EN adds out_err, flagging an
// encode request vector with more than one bit set.
module code_convert_pipe #(
  parameter int N  = 4,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  code_convert_pipe_if.slave   bus,
  output logic [CW-1:0]        xfer_cnt
);
  localparam int W = 2 ** N;

  logic         accept;
  logic         drain;
  logic [N-1:0] enc_idx;
  logic         enc_none;
  logic [W-1:0] nxt_data;
  logic         nxt_none;

  // A new word may enter when enabled and the output slot is empty or emptying.
  assign bus.in_ready = en && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = bus.out_valid && bus.out_ready;

  // Conversion of the presented word according to the mode sampled with it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    enc_idx  = '0;
    enc_none = 1'b1;
    nxt_data = '0;
    nxt_none = 1'b0;
    // Ascending scan: the last set bit seen is the highest, which wins.
    for (int i = 0; i < W; i++) begin
      if (bus.in_data[i]) begin
        enc_idx  = N'(i);
        enc_none = 1'b0;
      end
    end
    if (bus.mode) begin
      nxt_data = {{(W-N){1'b0}}, enc_idx};
      nxt_none = enc_none;
    end else begin
      nxt_data = W'(1) << bus.in_data[N-1:0];
      nxt_none = 1'b0;
    end
  end

  // Output register: load on accept, empty on a drain without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_none  <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= nxt_data;
      bus.out_none  <= nxt_none;
    end else if (drain) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef CODE_CONV_ONEHOT_CHK_EN
  logic nxt_err;

  // Multiple-request flag: clearing the lowest set bit leaves something behind.
  assign nxt_err = bus.mode && ((bus.in_data & (bus.in_data - W'(1))) != '0);

  // Error flag travels with the result it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_err <= 1'b0;
    end else if (accept) begin
      bus.out_err <= nxt_err;
    end
  end
`endif

  // Completed output handshakes, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (drain && (xfer_cnt != '1)) begin
      xfer_cnt <= xfer_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_code_convert_pipe.sv
// Directed testbench for code_convert_pipe: decode sweep, encode vectors,
// backpressure, enable, mid-stream reset, and counter saturation (CW=4 copy).
module tb_code_convert_pipe;
  logic        clk;
  logic        rst_n;
  logic        en;
  logic        en_s;
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer_cnt_s;

  int checks = 0;
  int errors = 0;

  code_convert_pipe_if #(.N(4)) bus   ();
  code_convert_pipe_if #(.N(4)) bus_s ();

  code_convert_pipe #(.N(4), .CW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .bus      (bus),
    .xfer_cnt (xfer_cnt)
  );

  code_convert_pipe #(.N(4), .CW(4)) dut_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_s),
    .bus      (bus_s),
    .xfer_cnt (xfer_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic        none;
    logic        err;
  } enc_vec_t;

  enc_vec_t enc_tab[5] = '{
    '{16'h0090, 16'h0007, 1'b0, 1'b1},
    '{16'h8001, 16'h000F, 1'b0, 1'b1},
    '{16'h0000, 16'h0000, 1'b1, 1'b0},
    '{16'h0010, 16'h0004, 1'b0, 1'b0},
    '{16'h0001, 16'h0000, 1'b0, 1'b0}
  };

  logic [15:0] cnt_before;

  initial begin
    rst_n          = 1'b0;
    en             = 1'b0;
    en_s           = 1'b1;
    bus.mode       = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus_s.mode     = 1'b0;
    bus_s.in_valid = 1'b0;
    bus_s.in_data  = '0;
    bus_s.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_out_none",  32'(bus.out_none),  32'd0);
    check("rst_xfer_cnt",  32'(xfer_cnt),      32'd0);
`ifdef CODE_CONV_ONEHOT_CHK_EN
    check("rst_out_err",   32'(bus.out_err),   32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();

    // 1: decode sweep, upper input bits are junk and must be ignored
    en            = 1'b1;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {12'hABC, 4'(i)};
      step();
      check($sformatf("dec_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("dec_data_%0d", i),  32'(bus.out_data),  32'(16'h0001 << i));
      check($sformatf("dec_none_%0d", i),  32'(bus.out_none),  32'd0);
    end
    bus.in_valid = 1'b0;
    step();
    check("dec_drained", 32'(bus.out_valid), 32'd0);
    check("dec_xfer_cnt", 32'(xfer_cnt), 32'd16);

    // 2: priority encode vectors
    bus.mode = 1'b1;
    foreach (enc_tab[k]) begin
      bus.in_valid = 1'b1;
      bus.in_data  = enc_tab[k].din;
      step();
      check($sformatf("enc_data_%h", enc_tab[k].din), 32'(bus.out_data), 32'(enc_tab[k].dout));
      check($sformatf("enc_none_%h", enc_tab[k].din), 32'(bus.out_none), 32'(enc_tab[k].none));
`ifdef CODE_CONV_ONEHOT_CHK_EN
      check($sformatf("enc_err_%h", enc_tab[k].din), 32'(bus.out_err), 32'(enc_tab[k].err));
`endif
    end
    bus.in_valid = 1'b0;
    step();

    // 3: backpressure, then drain+refill in the same cycle
    bus.mode     = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0003;
    step();
    check("bp_load", 32'(bus.out_data), 32'h0008);
    bus.out_ready = 1'b0;
    bus.mode      = 1'b1;
    bus.in_data   = 16'h0005;
    #1;
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp_hold_data_%0d", c),  32'(bus.out_data),  32'h0008);
      check($sformatf("bp_hold_valid_%0d", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_hold_ready_%0d", c), 32'(bus.in_ready),  32'd0);
    end
    cnt_before    = xfer_cnt;
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", 32'(bus.in_ready), 32'd1);
    step();
    check("bp_refill_valid", 32'(bus.out_valid), 32'd1);
    check("bp_refill_data",  32'(bus.out_data),  32'h0002);
    check("bp_refill_cnt",   32'(xfer_cnt),      32'(cnt_before + 16'd1));
    bus.in_valid = 1'b0;
    step();
    check("bp_empty", 32'(bus.out_valid), 32'd0);

    // 4: global enable
    bus.mode      = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0002;
    bus.out_ready = 1'b0;
    step();
    check("en_load", 32'(bus.out_data), 32'h0004);
    en          = 1'b0;
    bus.in_data = 16'h0007;
    #1;
    check("en_off_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("en_off_hold", 32'(bus.out_data), 32'h0004);
    bus.out_ready = 1'b1;
    step();
    check("en_off_drain", 32'(bus.out_valid), 32'd0);
    step();
    check("en_off_no_accept", 32'(bus.out_valid), 32'd0);
    en = 1'b1;
    #1;
    check("en_on_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("en_on_valid", 32'(bus.out_valid), 32'd1);
    check("en_on_data",  32'(bus.out_data),  32'h0080);

    // 5: asynchronous reset while a result is held
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    check("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data",  32'(bus.out_data),  32'h0);
    check("mid_rst_none",  32'(bus.out_none),  32'd0);
    check("mid_rst_cnt",   32'(xfer_cnt),      32'd0);
    step();
    rst_n        = 1'b1;
    bus.out_ready = 1'b1;
    bus.mode     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0400;
    #1;
    check("post_rst_empty", 32'(bus.out_valid), 32'd0);
    step();
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_data",  32'(bus.out_data),  32'h000A);
    bus.in_valid = 1'b0;
    step();

    // 6: saturation on the CW=4 instance; k steps give k-1 handshakes
    bus_s.mode      = 1'b0;
    bus_s.in_data   = 16'h0000;
    bus_s.in_valid  = 1'b1;
    bus_s.out_ready = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step();
      if (k == 10) check("sat_cnt_9",  32'(xfer_cnt_s), 32'd9);
      if (k == 16) check("sat_cnt_15", 32'(xfer_cnt_s), 32'hF);
      if (k == 17) check("sat_hold_a", 32'(xfer_cnt_s), 32'hF);
    end
    check("sat_hold_20", 32'(xfer_cnt_s), 32'hF);
    bus_s.in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
